// File: rtl/lu_seq_pkg.sv
// lu_seq_pkg: shared state encoding, coefficient slot indices and error codes.
// Revision 1.0 - initial release.
`default_nettype none

package lu_seq_pkg;

  localparam int NUM_COEF = 12;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [3:0] SLOT_A00 = 4'd0;
  localparam logic [3:0] SLOT_A01 = 4'd1;
  localparam logic [3:0] SLOT_A02 = 4'd2;
  localparam logic [3:0] SLOT_A10 = 4'd3;
  localparam logic [3:0] SLOT_A11 = 4'd4;
  localparam logic [3:0] SLOT_A12 = 4'd5;
  localparam logic [3:0] SLOT_A20 = 4'd6;
  localparam logic [3:0] SLOT_A21 = 4'd7;
  localparam logic [3:0] SLOT_A22 = 4'd8;
  localparam logic [3:0] SLOT_C0  = 4'd9;
  localparam logic [3:0] SLOT_C1  = 4'd10;
  localparam logic [3:0] SLOT_C2  = 4'd11;

  localparam logic [2:0] ERR_NONE = 3'b000;
  localparam logic [2:0] ERR_DBZ  = 3'b001;
  localparam logic [2:0] ERR_OVF  = 3'b010;
  localparam logic [2:0] ERR_FSM  = 3'b011;
  localparam logic [2:0] ERR_TMO  = 3'b100;

endpackage

`default_nettype wire

// File: rtl/lu_coef_regfile.sv
// lu_coef_regfile: 12-entry write-indexed coefficient bank, flattened for the solver.
// Revision 1.0 - initial release.
`default_nettype none

module lu_coef_regfile
  import lu_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [3:0]                 waddr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [NUM_COEF*DATA_W-1:0] coef_flat
);

  logic [DATA_W-1:0] bank [NUM_COEF];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_COEF; k++) bank[k] <= '0;
    end else if (we) begin
      bank[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < NUM_COEF; g++) begin : g_flat
    assign coef_flat[g*DATA_W +: DATA_W] = bank[g];
  end

endmodule

`default_nettype wire

// File: rtl/lu_solve_sequencer.sv
// lu_solve_sequencer: coefficient entry and run control for a 3x3 LU solver.
// Revision 1.0 - optional RUN timeout enabled by defining LU_SEQ_TIMEOUT_EN.
`default_nettype none

module lu_solve_sequencer
  import lu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DATA_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       entry_valid,
  input  logic [DATA_W-1:0]          entry_data,
  output logic                       entry_ready,
  output logic [3:0]                 entry_idx,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       abort,
  output logic [NUM_COEF*DATA_W-1:0] coef_flat,
  output logic                       lu_en,
  input  logic                       lu_done,
  input  logic                       lu_err_ovf,
  input  logic                       lu_err_dbz,
  input  logic                       lu_err_fsm,
  input  logic [DATA_W-1:0]          x0,
  input  logic [DATA_W-1:0]          x1,
  input  logic [DATA_W-1:0]          x2,
  output logic [DATA_W-1:0]          res_x0,
  output logic [DATA_W-1:0]          res_x1,
  output logic [DATA_W-1:0]          res_x2,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 err_code,
  output logic [2:0]                 state_out
);

  state_t     state;
  logic [2:0] err_q;
  logic [3:0] idx;
  logic       coef_we;

`ifdef LU_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tcnt;
`endif

  // abort must also block the write that would otherwise land this cycle
  assign coef_we = (state == ST_LOAD) && entry_valid && !abort;

  lu_coef_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (coef_we),
    .waddr     (idx),
    .wdata     (entry_data),
    .coef_flat (coef_flat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_LOAD;
      idx    <= '0;
      err_q  <= ERR_NONE;
      res_x0 <= '0;
      res_x1 <= '0;
      res_x2 <= '0;
`ifdef LU_SEQ_TIMEOUT_EN
      tcnt   <= '0;
`endif
    end else if (abort) begin
      state <= ST_LOAD;
      idx   <= '0;
      err_q <= ERR_NONE;
    end else begin
      case (state)
        ST_LOAD: begin
          if (entry_valid) begin
            if (idx == SLOT_C2) begin
              idx   <= '0;
              state <= ST_READY;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_READY: begin
          if (start) begin
            state <= ST_RUN;
`ifdef LU_SEQ_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end
        end
        ST_RUN: begin
          // errors outrank a simultaneous lu_done; lu_done outranks timeout
          if (lu_err_dbz) begin
            state <= ST_ERR;
            err_q <= ERR_DBZ;
          end else if (lu_err_ovf) begin
            state <= ST_ERR;
            err_q <= ERR_OVF;
          end else if (lu_err_fsm) begin
            state <= ST_ERR;
            err_q <= ERR_FSM;
          end else if (lu_done) begin
            state  <= ST_DONE;
            res_x0 <= x0;
            res_x1 <= x1;
            res_x2 <= x2;
`ifdef LU_SEQ_TIMEOUT_EN
          end else if (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state <= ST_ERR;
            err_q <= ERR_TMO;
          end else begin
            tcnt <= tcnt + 1'b1;
`endif
          end
        end
        ST_DONE: begin
          if (clear) begin
            state <= ST_LOAD;
            idx   <= '0;
          end else if (start) begin
            state <= ST_RUN;
`ifdef LU_SEQ_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end
        end
        ST_ERR: begin
          if (clear) begin
            state <= ST_LOAD;
            idx   <= '0;
            err_q <= ERR_NONE;
          end
        end
        default: begin
          state <= ST_LOAD;
          idx   <= '0;
          err_q <= ERR_NONE;
        end
      endcase
    end
  end

  assign entry_ready = (state == ST_LOAD);
  assign entry_idx   = idx;
  assign lu_en       = (state == ST_RUN);
  assign busy        = (state == ST_RUN);
  assign done        = (state == ST_DONE);
  assign err_code    = err_q;
  assign state_out   = state;

endmodule

`default_nettype wire
